// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller for the shared immediate generator: decodes opcode/funct3
// into an immediate-type select and buffers {imm, type, pc, illegal} in a 2-entry skid FIFO.
`timescale 1ns/1ps
module imm_decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [24:0] gen_inst_31_7,
  output logic [2:0]  gen_imm_type,
  input  logic [31:0] gen_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_type,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam logic [2:0] R_TYPE     = 3'd0;
  localparam logic [2:0] I_TYPE     = 3'd1;
  localparam logic [2:0] ISTAR_TYPE = 3'd2;
  localparam logic [2:0] S_TYPE     = 3'd3;
  localparam logic [2:0] B_TYPE     = 3'd4;
  localparam logic [2:0] U_TYPE     = 3'd5;
  localparam logic [2:0] J_TYPE     = 3'd6;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic [31:0] pc;
    logic        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] dec_type;
  logic       dec_illegal;
  logic       dec_zero_imm;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // NOTE: every output of a combinational block gets a default up front; without it
  // any case arm that skips an assignment infers a latch.
  always_comb begin
    dec_type     = R_TYPE;
    dec_illegal  = 1'b0;
    dec_zero_imm = 1'b0;
    unique case (opcode)
      7'b0010011: dec_type = (funct3 == 3'b001 || funct3 == 3'b101) ? ISTAR_TYPE : I_TYPE;
      7'b0000011,
      7'b1100111,
      7'b1110011: dec_type = I_TYPE;
      7'b0100011: dec_type = S_TYPE;
      7'b1100011: dec_type = B_TYPE;
      7'b0110111,
      7'b0010111: dec_type = U_TYPE;
      7'b1101111: dec_type = J_TYPE;
      7'b0110011: dec_zero_imm = 1'b1;
      default: begin
        dec_zero_imm = 1'b1;
        dec_illegal  = 1'b1;
      end
    endcase
  end

  assign gen_inst_31_7 = in_inst[31:7];
  assign gen_imm_type  = dec_type;

  // Reset asserts asynchronously but releases on a clock edge, so no flop sees a
  // deassertion racing the clock.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  entry_t     new_entry;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // R-type and unknown opcodes never let the generator's don't-care value into storage.
  assign new_entry = '{imm:      dec_zero_imm ? 32'h0 : gen_imm,
                       imm_type: dec_type,
                       pc:       in_pc,
                       illegal:  dec_illegal};

  // NOTE: the entry storage is reset along with the pointers so an empty buffer still
  // presents all-zero outputs; sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_imm      = mem[rd_ptr].imm;
  assign out_imm_type = mem[rd_ptr].imm_type;
  assign out_pc       = mem[rd_ptr].pc;
  assign out_illegal  = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl with a behavioural stand-in for ImmGenDP.
`timescale 1ns/1ps
module tb_imm_decode_ctrl;

  localparam logic [2:0] R_T = 3'd0, I_T = 3'd1, IS_T = 3'd2, S_T = 3'd3,
                         B_T = 3'd4, U_T = 3'd5, J_T = 3'd6;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, gen_imm, out_imm, out_pc;
  logic [24:0] gen_inst_31_7;
  logic [2:0]  gen_imm_type, out_imm_type;

  int checks = 0;
  int errors = 0;

  imm_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .gen_inst_31_7(gen_inst_31_7), .gen_imm_type(gen_imm_type), .gen_imm(gen_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_imm_type(out_imm_type), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ImmGenDP reference: RV32I immediate formats; R-type yields x on purpose.
  logic [31:0] gi;
  assign gi = {gen_inst_31_7, 7'b0};
  always_comb begin
    case (gen_imm_type)
      I_T:     gen_imm = {{20{gi[31]}}, gi[31:20]};
      IS_T:    gen_imm = {27'b0, gi[24:20]};
      S_T:     gen_imm = {{20{gi[31]}}, gi[31:25], gi[11:7]};
      B_T:     gen_imm = {{19{gi[31]}}, gi[31], gi[7], gi[30:25], gi[11:8], 1'b0};
      U_T:     gen_imm = {gi[31:12], 12'b0};
      J_T:     gen_imm = {{11{gi[31]}}, gi[31], gi[19:12], gi[20], gi[30:21], 1'b0};
      default: gen_imm = 'x;
    endcase
  end

  logic [68:0] head;
  assign head = {out_valid, out_imm, out_imm_type, out_pc, out_illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [68:0] exp;
    exp = '0;
    @(negedge clk);
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL reset_head got %h want %h", head, exp);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    release_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_ready_valid got %b want 10", {in_ready, out_valid});
    end
    tick();
  endtask

  task automatic test_addi_slli();
    logic [68:0] exp;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h0000_0100);
    @(negedge clk);
    checks++;
    if ({gen_imm_type, gen_inst_31_7} !== {I_T, 25'h1FFE001}) begin
      errors++;
      $display("FAIL addi_gen got %h want %h", {gen_imm_type, gen_inst_31_7}, {I_T, 25'h1FFE001});
    end
    tick();
    drive(1'b1, 32'h00509093, 32'h0000_0104);
    @(negedge clk);
    exp = {1'b1, 32'hFFFFFFFF, I_T, 32'h0000_0100, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL addi_head got %h want %h", head, exp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp = {1'b1, 32'h00000005, IS_T, 32'h0000_0104, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL slli_head got %h want %h", head, exp);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_slli_drain got %b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3] = '{32'hFE112E23, 32'h123452B7, 32'hFF9FF06F};
    logic [31:0] imms  [3] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8};
    logic [2:0]  types [3] = '{S_T, U_T, J_T};
    logic [68:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, insts[i], 32'h200 + 32'(4 * i));
      else       drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      if (i > 0) begin
        exp = {1'b1, imms[i-1], types[i-1], 32'h200 + 32'(4 * (i - 1)), 1'b0};
        checks++;
        if (head !== exp || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_head%0d got %h rdy %b want %h rdy 1", i - 1, head, in_ready, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [68:0] exp;
    out_ready = 1'b0;
    drive(1'b1, 32'hFE112E23, 32'h300);
    tick();
    drive(1'b1, 32'h123452B7, 32'h304);
    tick();
    drive(1'b1, 32'hFF9FF06F, 32'h308);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_in_ready got %b want 0", in_ready);
    end
    exp = {1'b1, 32'hFFFFFFFC, S_T, 32'h300, 1'b0};
    tick();
    @(negedge clk);
    checks++;
    if (head !== exp || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got %h rdy %b want %h rdy 0", head, in_ready, exp);
    end
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    exp = {1'b1, 32'h12345000, U_T, 32'h304, 1'b0};
    checks++;
    if (head !== exp || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_pop got %h rdy %b want %h rdy 1", head, in_ready, exp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp = {1'b1, 32'hFFFFFFF8, J_T, 32'h308, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL bp_third got %h want %h", head, exp);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [68:0] exp;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h400);
    tick();
    drive(1'b1, 32'h002081B3, 32'h404);
    @(negedge clk);
    exp = {1'b1, 32'h0, R_T, 32'h400, 1'b1};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL illegal_head got %h want %h", head, exp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp = {1'b1, 32'h0, R_T, 32'h404, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL add_head got %h want %h", head, exp);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [68:0] exp;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h500);
    tick();
    drive(1'b1, 32'h00509093, 32'h504);
    tick();
    drive(1'b1, 32'h123452B7, 32'h508);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_state got %b want 01", {out_valid, in_ready});
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_capture got %b want 0", out_valid);
    end
    drive(1'b1, 32'hFE112E23, 32'h50C);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp = {1'b1, 32'hFFFFFFFC, S_T, 32'h50C, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL post_flush_head got %h want %h", head, exp);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [68:0] exp;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h600);
    tick();
    drive(1'b1, 32'h123452B7, 32'h604);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (head !== exp || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got %h rdy %b want %h rdy 1", head, in_ready, exp);
    end
    release_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h00509093, 32'h700);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_push_early got %b want 0", out_valid);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp = {1'b1, 32'h00000005, IS_T, 32'h700, 1'b0};
    checks++;
    if (head !== exp) begin
      errors++;
      $display("FAIL rst_first_push got %h want %h", head, exp);
    end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    test_reset();
    test_addi_slli();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage controller for the shared immediate generator in stage 1. It accepts instructions over a valid/ready handshake and decodes opcode/funct3 into the immediate-type select. It drives the combinational `ImmGenDP` datapath with that select and the instruction bits, then captures the result with the PC and an illegal-opcode flag into a 2-entry skid buffer. The buffer feeds the stage-1/stage-2 boundary under downstream backpressure and pipeline flush.

## Interface
- No parameters; all widths fixed (RV32I).
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all buffered entries and the current input.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  32  PC of in_inst.
- gen_inst_31_7  output  25  to ImmGenDP: in_inst[31:7], combinational.
- gen_imm_type  output  3  to ImmGenDP: decoded type, combinational; encodings per `stage1/stage1_control.vh`.
- gen_imm  input  32  from ImmGenDP: generated immediate.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry.
- out_imm  output  32  head entry immediate.
- out_imm_type  output  3  head entry type.
- out_pc  output  32  head entry PC.
- out_illegal  output  1  head entry opcode unrecognised.

## Operation
- Decode from in_inst[6:0], with funct3 = in_inst[14:12]:
  - 0010011 with funct3 001/101 → ISTAR_TYPE; other funct3 → I_TYPE.
  - 0000011, 1100111, 1110011 → I_TYPE.
  - 0100011 → S_TYPE; 1100011 → B_TYPE.
  - 0110111, 0010111 → U_TYPE; 1101111 → J_TYPE.
  - 0110011 → R_TYPE; stored imm forced to 32'h0, never gen_imm's x.
  - Any other opcode → R_TYPE, imm 32'h0, illegal=1.
- gen_* outputs track in_inst every cycle, whether or not in_valid is high.
- Storage: 2-entry FIFO of {imm, imm_type, pc, illegal}, with read pointer, write pointer (1 bit each) and count (0..2).
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- in_ready = (count != 2). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_* are driven from the entry at the read pointer.
- Simultaneous push and pop at count 1 leaves count at 1, with both pointers advancing.
- Flush sets count=0 and resets both pointers to 0. Input and pop are ignored that cycle. Flush has priority over everything.

## Timing
- Reset (async assert, sync deassert inside the block): count=0, pointers=0, all entry storage 0. So out_valid=0, out_imm=0, out_imm_type=0, out_pc=0, out_illegal=0, and in_ready=1.
- Latency: an instruction accepted in cycle N is visible on out_* with out_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- With out_ready=0: 2 accepts, then in_ready drops in the cycle after the second accept. in_ready rises the cycle after the first pop.
- Held entries are stable (no out_* change) while out_valid=1 and out_ready=0.
- Flush at cycle N: out_valid=0 and in_ready=1 from cycle N+1.
- rst_n asserted mid-transfer: all state clears immediately, independent of clk.

## Test plan
- addi 0xFFF00093, then slli 0x00509093, out_ready=1 → in the following two cycles: out_imm 0xFFFFFFFF with I_TYPE, then out_imm 0x00000005 with ISTAR_TYPE. PCs match, 1-cycle latency.
- sw 0xFE112E23, lui 0x123452B7, jal 0xFF9FF06F back-to-back → out_imm 0xFFFFFFFC (S), 0x12345000 (U), 0xFFFFFFF8 (J), in order.
- out_ready=0, push 3 instructions → first two accepted, in_ready=0 on the third. Raise out_ready → third accepted the cycle after the first pop, order preserved, no loss or duplication.
- 0x0000007F and add 0x002081B3 → out_illegal=1 for the first, 0 for the second. Both have R_TYPE and out_imm 0x00000000.
- 2 entries buffered, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed-cycle input is not captured.
- Assert rst_n=0 mid-stream, between clock edges → all outputs 0 and in_ready=1 immediately. After release, the first push behaves as from reset.
